ntt_job_arbiter: RTL and testbench

// Shares one ntt_memory_wrapper instance between two requesters (e.g. FNTT and INTT job sources).
// - Arbitrates level requests round-robin.
// - Drives the wrapper start/intt controls, then routes its memory ports to the granted requester.
// - Reports per-job completion, timeout error and cycle count.

---
 rtl/ntt_job_arbiter.sv | 146 ++++++++++++++
 tb/tb_ntt_job_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_job_arbiter.sv
// Round-robin arbiter that shares one ntt_memory_wrapper between two job requesters.
// Owns the wrapper start/intt controls and routes the wrapper memory ports to the granted side.
module ntt_job_arbiter #(
    parameter int LOGQ       = 64,
    parameter int LOGN       = 12,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 2**20,
    parameter int GAP_CYCLES = 2,
    localparam int AW        = (LOGN < 9) ? 10 : LOGN
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_0,
    input  logic             req_intt_0,
    output logic             gnt_0,
    output logic             done_0,
    output logic             err_0,
    output logic [AW-1:0]    rd_addr_0,
    output logic [AW-1:0]    wr_addr_0,
    output logic             wea_0,
    input  logic [LOGQ-1:0]  din0_0,
    input  logic [LOGQ-1:0]  din1_0,

    input  logic             req_1,
    input  logic             req_intt_1,
    output logic             gnt_1,
    output logic             done_1,
    output logic             err_1,
    output logic [AW-1:0]    rd_addr_1,
    output logic [AW-1:0]    wr_addr_1,
    output logic             wea_1,
    input  logic [LOGQ-1:0]  din0_1,
    input  logic [LOGQ-1:0]  din1_1,

    output logic             ntt_start,
    output logic             ntt_intt,
    input  logic [AW-1:0]    ntt_rd_addr,
    input  logic [AW-1:0]    ntt_wr_addr,
    input  logic             ntt_wea,
    output logic [LOGQ-1:0]  ntt_din0,
    output logic [LOGQ-1:0]  ntt_din1,
    input  logic             ntt_finish,

    output logic             busy,
    output logic [CNT_W-1:0] job_cycles,
    output logic             job_cyc_vld
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             pick_1;

    // Requester 1 wins when it is alone or when the tie pointer favours it.
    assign pick_1 = req_1 & (~req_0 | rr_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            cnt         <= '0;
            gap_cnt     <= '0;
            gnt_0       <= 1'b0;
            gnt_1       <= 1'b0;
            done_0      <= 1'b0;
            done_1      <= 1'b0;
            err_0       <= 1'b0;
            err_1       <= 1'b0;
            ntt_start   <= 1'b0;
            ntt_intt    <= 1'b0;
            job_cycles  <= '0;
            job_cyc_vld <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so only the exit branch can raise them.
            done_0      <= 1'b0;
            done_1      <= 1'b0;
            err_0       <= 1'b0;
            err_1       <= 1'b0;
            job_cyc_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_0 | req_1) begin
                        gnt_0     <= ~pick_1;
                        gnt_1     <= pick_1;
                        ntt_start <= 1'b1;
                        ntt_intt  <= pick_1 ? req_intt_1 : req_intt_0;
                        cnt       <= '0;
                        if (req_0 & req_1)
                            rr_ptr <= ~pick_1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (ntt_finish || cnt == CNT_LAST) begin
                        ntt_start   <= 1'b0;
                        gnt_0       <= 1'b0;
                        gnt_1       <= 1'b0;
                        done_0      <= gnt_0;
                        done_1      <= gnt_1;
                        err_0       <= gnt_0 & ~ntt_finish;
                        err_1       <= gnt_1 & ~ntt_finish;
                        job_cycles  <= cnt;
                        job_cyc_vld <= 1'b1;
                        state       <= DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    // A wrapper still signalling finish holds the arbiter here.
                    if (gap_cnt >= GAP_LAST && !ntt_finish)
                        state <= IDLE;
                    else if (gap_cnt < GAP_LAST)
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    assign rd_addr_0 = gnt_0 ? ntt_rd_addr : '0;
    assign wr_addr_0 = gnt_0 ? ntt_wr_addr : '0;
    assign wea_0     = ntt_wea & gnt_0;
    assign rd_addr_1 = gnt_1 ? ntt_rd_addr : '0;
    assign wr_addr_1 = gnt_1 ? ntt_wr_addr : '0;
    assign wea_1     = ntt_wea & gnt_1;

    // Zero-latency read-data mux keeps the wrapper's BRAM read timing intact.
    assign ntt_din0 = gnt_0 ? din0_0 : gnt_1 ? din0_1 : '0;
    assign ntt_din1 = gnt_0 ? din1_0 : gnt_1 ? din1_1 : '0;

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// Directed bench for ntt_job_arbiter; the bench plays the role of the shared wrapper.
module tb_ntt_job_arbiter;

    localparam int LOGQ  = 8;
    localparam int LOGN  = 4;
    localparam int AW    = 10;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_0 = 1'b0, req_intt_0 = 1'b0, req_1 = 1'b0, req_intt_1 = 1'b0;
    logic             gnt_0, done_0, err_0, wea_0, gnt_1, done_1, err_1, wea_1;
    logic [AW-1:0]    rd_addr_0, wr_addr_0, rd_addr_1, wr_addr_1;
    logic [LOGQ-1:0]  din0_0 = '0, din1_0 = '0, din0_1 = '0, din1_1 = '0;
    logic             ntt_start, ntt_intt, busy, job_cyc_vld;
    logic [AW-1:0]    ntt_rd_addr = '0, ntt_wr_addr = '0;
    logic             ntt_wea = 1'b0, ntt_finish = 1'b0;
    logic [LOGQ-1:0]  ntt_din0, ntt_din1;
    logic [CNT_W-1:0] job_cycles;

    int checks = 0;
    int errors = 0;

    ntt_job_arbiter #(
        .LOGQ(LOGQ), .LOGN(LOGN), .CNT_W(CNT_W), .TIMEOUT(100), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_intt_0(req_intt_0), .gnt_0(gnt_0), .done_0(done_0), .err_0(err_0),
        .rd_addr_0(rd_addr_0), .wr_addr_0(wr_addr_0), .wea_0(wea_0), .din0_0(din0_0), .din1_0(din1_0),
        .req_1(req_1), .req_intt_1(req_intt_1), .gnt_1(gnt_1), .done_1(done_1), .err_1(err_1),
        .rd_addr_1(rd_addr_1), .wr_addr_1(wr_addr_1), .wea_1(wea_1), .din0_1(din0_1), .din1_1(din1_1),
        .ntt_start(ntt_start), .ntt_intt(ntt_intt), .ntt_rd_addr(ntt_rd_addr), .ntt_wr_addr(ntt_wr_addr),
        .ntt_wea(ntt_wea), .ntt_din0(ntt_din0), .ntt_din1(ntt_din1), .ntt_finish(ntt_finish),
        .busy(busy), .job_cycles(job_cycles), .job_cyc_vld(job_cyc_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic grant_check(input int k, input logic intt);
        check("gnt_0", gnt_0, k == 0);
        check("gnt_1", gnt_1, k == 1);
        check("start", ntt_start, 1);
        check("intt", ntt_intt, intt);
        check("busy_run", busy, 1);
    endtask

    task automatic end_check(input int k, input int cyc, input logic err);
        check("done_0", done_0, k == 0);
        check("done_1", done_1, k == 1);
        check("err_0", err_0, (k == 0) && err);
        check("err_1", err_1, (k == 1) && err);
        check("job_cycles", job_cycles, cyc);
        check("job_cyc_vld", job_cyc_vld, 1);
        check("start_off", ntt_start, 0);
        check("gnt_off", {gnt_1, gnt_0}, 0);
    endtask

    // Walk DONE -> GAP -> GAP -> IDLE; requests raised mid-gap must be ignored.
    task automatic gap_pass(input bit raise0, input bit raise1);
        tick();
        check("done_pulse", {done_1, done_0, job_cyc_vld}, 0);
        check("busy_gap1", busy, 1);
        if (raise0) req_0 = 1'b1;
        if (raise1) req_1 = 1'b1;
        tick();
        check("busy_gap2", busy, 1);
        check("gnt_gap", {gnt_1, gnt_0}, 0);
        tick();
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        check("rst_gnt", {gnt_1, gnt_0}, 0);
        check("rst_start", ntt_start, 0);
        check("rst_intt", ntt_intt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", {done_1, done_0, err_1, err_0, job_cyc_vld}, 0);
        check("rst_cycles", job_cycles, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Single forward job for requester 0, plus port routing
        din0_0 = 8'hA5; din1_0 = 8'h3C; din0_1 = 8'h11; din1_1 = 8'h22;
        ntt_rd_addr = 10'h155; ntt_wr_addr = 10'h2AA; ntt_wea = 1'b1;
        req_0 = 1'b1;
        #1;
        check("din0_nognt", ntt_din0, 0);
        tick();
        grant_check(0, 0);
        check("rd_addr_0", rd_addr_0, 10'h155);
        check("wr_addr_0", wr_addr_0, 10'h2AA);
        check("wea_0", wea_0, 1);
        check("rd_addr_1", rd_addr_1, 0);
        check("wea_1", wea_1, 0);
        check("ntt_din0", ntt_din0, 8'hA5);
        check("ntt_din1", ntt_din1, 8'h3C);
        tick(5);
        ntt_finish = 1'b1;
        tick();
        end_check(0, 5, 0);
        req_0 = 1'b0;
        // finish held high keeps the arbiter in GAP past GAP_CYCLES
        tick();
        check("done_1cyc", done_0, 0);
        tick(2);
        check("gap_hold", busy, 1);
        ntt_finish = 1'b0;
        tick();
        check("gap_release", busy, 0);

        // Tie after reset: 0 first, then 1
        req_0 = 1'b1; req_1 = 1'b1; req_intt_1 = 1'b1;
        tick();
        grant_check(0, 0);
        tick(2);
        ntt_finish = 1'b1;
        tick();
        end_check(0, 2, 0);
        ntt_finish = 1'b0; req_0 = 1'b0;
        gap_pass(0, 0);
        tick();
        grant_check(1, 1);
        req_0 = 1'b1;
        // Isolation of requester 0 while 1 runs
        for (int i = 0; i < 6; i++) begin
            din0_0 = LOGQ'($urandom); din1_0 = LOGQ'($urandom);
            #1;
            check("iso_din0", ntt_din0, 8'h11);
            check("iso_din1", ntt_din1, 8'h22);
            check("iso_wea_0", wea_0, 0);
            check("iso_rd_0", {wr_addr_0, rd_addr_0}, 0);
            tick();
        end
        ntt_finish = 1'b1;
        tick();
        end_check(1, 6, 0);
        ntt_finish = 1'b0; req_1 = 1'b0;
        gap_pass(0, 1);
        // Tie with pointer at 1
        tick();
        grant_check(1, 1);
        tick(3);
        ntt_finish = 1'b1;
        tick();
        end_check(1, 3, 0);
        ntt_finish = 1'b0; req_1 = 1'b0;
        gap_pass(0, 1);
        // Tie with pointer back at 0
        tick();
        grant_check(0, 0);
        tick();
        ntt_finish = 1'b1;
        tick();
        end_check(0, 1, 0);
        ntt_finish = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
        gap_pass(0, 0);

        // Timeout with finish tied low
        req_0 = 1'b1;
        tick();
        grant_check(0, 0);
        tick(99);
        check("to_not_yet", done_0, 0);
        check("to_start", ntt_start, 1);
        tick();
        end_check(0, 99, 1);
        req_0 = 1'b0;
        gap_pass(0, 0);

        // Finish on the timeout cycle counts as a normal finish
        req_0 = 1'b1;
        tick();
        grant_check(0, 0);
        tick(99);
        ntt_finish = 1'b1;
        tick();
        end_check(0, 99, 0);
        ntt_finish = 1'b0; req_0 = 1'b0;
        gap_pass(0, 0);

        // Reset mid-RUN, pointer returns to 0
        req_1 = 1'b1;
        tick();
        grant_check(1, 1);
        tick(10);
        rst = 1'b1;
        tick();
        check("mrst_start", ntt_start, 0);
        check("mrst_gnt", {gnt_1, gnt_0}, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", {done_1, done_0, err_1, err_0, job_cyc_vld}, 0);
        rst = 1'b0; req_0 = 1'b1;
        tick();
        grant_check(0, 0);
        tick(4);
        ntt_finish = 1'b1;
        tick();
        end_check(0, 4, 0);
        ntt_finish = 1'b0; req_0 = 1'b0;
        gap_pass(0, 0);
        tick();
        grant_check(1, 1);
        tick(3);
        ntt_finish = 1'b1;
        tick();
        end_check(1, 3, 0);
        ntt_finish = 1'b0; req_1 = 1'b0;
        gap_pass(0, 0);

        // Withdrawn request from 1 while 0 runs
        req_0 = 1'b1;
        tick();
        grant_check(0, 0);
        tick(2);
        req_1 = 1'b1;
        tick();
        req_1 = 1'b0;
        tick();
        ntt_finish = 1'b1;
        tick();
        end_check(0, 4, 0);
        ntt_finish = 1'b0; req_0 = 1'b0;
        gap_pass(0, 0);
        tick(3);
        check("wd_gnt_1", gnt_1, 0);
        check("wd_busy", busy, 0);
        check("wd_done_1", done_1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
